screen_fb_arbiter: RTL

//  Owns the double-buffered HUB75 framebuffer (single-port sync RAM, 2 banks of 64x64 px, 4b/colour).

---
 rtl/screen_pkg.sv | 31 +++
 rtl/screen_fb_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/screen_pkg.sv
// Shared types and defaults for the HUB75 double-buffered framebuffer.
package screen_pkg;

   localparam int FB_ADDR_W = 12;   // 64x64 pixels per bank
   localparam int FB_DATA_W = 12;   // {R[3:0],G[3:0],B[3:0]}

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CLEAR     = 2'd1,
      SWAP_WAIT = 2'd2
   } fb_state_e;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } pixel_t;

   function automatic logic [3:0] px_red(input logic [FB_DATA_W-1:0] px);
      return px[11:8];
   endfunction

   function automatic logic [3:0] px_green(input logic [FB_DATA_W-1:0] px);
      return px[7:4];
   endfunction

   function automatic logic [3:0] px_blue(input logic [FB_DATA_W-1:0] px);
      return px[3:0];
   endfunction

endpackage

// File: rtl/screen_fb_arbiter.sv
// Framebuffer owner: arbitrates one RAM access per cycle between scan reads of the
// front bank and CPU writes/clears of the back bank, and swaps banks at frame ends.
module screen_fb_arbiter
   import screen_pkg::*;
#(
   parameter int                ADDR_W      = FB_ADDR_W,
   parameter int                DATA_W      = FB_DATA_W,
   parameter int                STARVE_MAX  = 8,
   parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              scan_req,
   input  logic [ADDR_W-1:0] scan_addr,
   output logic              scan_gnt,
   output logic              scan_valid,
   output logic [DATA_W-1:0] scan_data,
   input  logic              frame_end,
   input  logic              cpu_wr_valid,
   input  logic [ADDR_W-1:0] cpu_wr_addr,
   input  logic [DATA_W-1:0] cpu_wr_data,
   output logic              cpu_wr_ready,
   input  logic              cpu_clear,
   input  logic              cpu_swap,
   output logic              busy,
   output logic              front_buf,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W:0]   ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int STARVE_W = $clog2(STARVE_MAX + 1);

   fb_state_e           state;
   logic                swap_pend;
   logic [ADDR_W-1:0]   clr_addr;
   logic [STARVE_W-1:0] starve;

   logic in_idle;
   logic in_clear;
   logic cpu_side;
   logic force_slot;
   logic cpu_slot;

   // Slot decisions are gated by reset so the RAM strobes stay quiet while reset is held.
   assign in_idle      = (state == IDLE)  & ~reset;
   assign in_clear     = (state == CLEAR) & ~reset;
   assign cpu_side     = (in_idle & cpu_wr_valid) | in_clear;
   assign force_slot   = cpu_side & (starve == STARVE_W'(STARVE_MAX));
   assign scan_gnt     = scan_req & ~force_slot & ~reset;
   assign cpu_slot     = cpu_side & ~scan_gnt;
   assign cpu_wr_ready = in_idle & ~scan_gnt;
   assign busy         = (state != IDLE);
   assign scan_data    = scan_valid ? ram_rdata : '0;

   // NOTE: every output of a combinational block gets a value on every path, else a latch is inferred.
   always_comb begin
      ram_en    = scan_gnt | cpu_slot;
      ram_we    = cpu_slot;
      ram_wdata = in_clear ? CLEAR_COLOR : cpu_wr_data;
      if (scan_gnt)
         ram_addr = {front_buf, scan_addr};
      else if (in_clear)
         ram_addr = {~front_buf, clr_addr};
      else
         ram_addr = {~front_buf, cpu_wr_addr};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         front_buf  <= 1'b0;
         swap_pend  <= 1'b0;
         clr_addr   <= '0;
         starve     <= '0;
         scan_valid <= 1'b0;
      end else begin
         scan_valid <= scan_gnt;

         if (cpu_side & scan_gnt)
            starve <= (starve == STARVE_W'(STARVE_MAX)) ? starve : starve + 1'b1;
         else
            starve <= '0;

         case (state)
            IDLE: begin
               if (cpu_clear) begin
                  state     <= CLEAR;
                  clr_addr  <= '0;
                  swap_pend <= cpu_swap;
               end else if (cpu_swap) begin
                  state <= SWAP_WAIT;
               end
            end
            CLEAR: begin
               if (cpu_swap)
                  swap_pend <= 1'b1;
               if (cpu_slot) begin
                  clr_addr <= clr_addr + 1'b1;
                  // Last pixel written: the wrap of clr_addr is never used as a write.
                  if (clr_addr == '1) begin
                     state     <= (swap_pend | cpu_swap) ? SWAP_WAIT : IDLE;
                     swap_pend <= 1'b0;
                  end
               end
            end
            SWAP_WAIT: begin
               if (frame_end) begin
                  front_buf <= ~front_buf;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
